// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: shared constants and types for the memory-mapped countdown timer.
//   - Bus bases and register byte offsets as seen by the system bridge.
//   - CTRL field positions and mode codes.
//   - FSM state type and register-select type used by timer_dev.
package timer_dev_pkg;

  // Instance bases (decoded by the bridge, not by the timer itself)
  localparam logic [31:0] TIMER0_BASE = 32'h0000_7f00;
  localparam logic [31:0] TIMER1_BASE = 32'h0000_7f10;

  // Register byte offsets within an instance
  localparam logic [3:0] TIMER_CTRL   = 4'h0;
  localparam logic [3:0] TIMER_PRESET = 4'h4;
  localparam logic [3:0] TIMER_COUNT  = 4'h8;

  // CTRL.Mode codes; 2'b1x is treated as one-shot
  localparam logic [1:0] TIMER_MODE_ONESHOT = 2'b00;
  localparam logic [1:0] TIMER_MODE_RELOAD  = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;
  localparam int CTRL_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // Word select taken from Addr[3:2]
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_t;

  function automatic logic is_reload(input logic [1:0] mode);
    return mode == TIMER_MODE_RELOAD;
  endfunction

endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer with interrupt request.
//   clk    in   system clock, all state on rising edge
//   reset  in   synchronous active-low reset
//   Addr   in   byte address, only Addr[3:2] decoded (CTRL/PRESET/COUNT/unused)
//   WE     in   write strobe, already qualified by the bridge chip select
//   Din    in   write data
//   Dout   out  combinational read data for the selected word
//   IRQ    out  CTRL.IM & irq_flag
// A CPU write always takes priority: on a write edge the FSM and COUNT hold.
module timer_dev
  import timer_dev_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       Addr,
  input  logic              WE,
  input  logic [DATA_W-1:0] Din,
  output logic [DATA_W-1:0] Dout,
  output logic              IRQ
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  state_t              state_reg, state_next;
  logic [CTRL_W-1:0]   ctrl_reg, ctrl_next;
  logic [DATA_W-1:0]   preset_reg, preset_next;
  logic [DATA_W-1:0]   count_reg, count_next;
  logic                irq_flag_reg, irq_flag_next;

  reg_sel_t            sel;
  logic                enable;
  logic [1:0]          mode;
  logic                count_last;

  // Only the word select matters; the bridge has already decoded the base.
  logic                addr_unused;
  assign addr_unused = ^{Addr[31:4], Addr[1:0]};

  assign sel        = reg_sel_t'(Addr[3:2]);
  assign enable     = ctrl_reg[CTRL_EN_BIT];
  assign mode       = ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB];
  // PRESET=0 behaves like PRESET=1: expiry fires on the first enabled CNT cycle.
  assign count_last = (count_reg <= ONE);

  // State and register file
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      ctrl_reg     <= '0;
      preset_reg   <= '0;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (!WE) begin
      unique case (state_reg)
        ST_IDLE: if (enable) state_next = ST_LOAD;
        ST_LOAD: state_next = ST_CNT;
        ST_CNT:  if (enable && count_last) state_next = ST_INT;
        ST_INT:  state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Register updates: bus writes, otherwise FSM-driven datapath
  always_comb begin
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    irq_flag_next = irq_flag_reg;
    if (WE) begin
      unique case (sel)
        REG_CTRL: begin
          ctrl_next     = Din[CTRL_W-1:0];
          irq_flag_next = 1'b0;   // software acknowledge
        end
        REG_PRESET: preset_next = Din;
        default: ;                // COUNT is read-only, offset 0xC ignored
      endcase
    end else begin
      unique case (state_reg)
        ST_IDLE: if (enable) irq_flag_next = 1'b0;
        ST_LOAD: count_next = preset_reg;
        ST_CNT: begin
          if (enable) begin
            if (count_last) begin
              count_next    = '0;
              irq_flag_next = 1'b1;
            end else begin
              count_next = count_reg - ONE;
            end
          end
        end
        ST_INT: begin
          // Auto-reload keeps Enable set so IDLE restarts the cycle; the flag
          // is dropped here so IRQ is a single-cycle pulse.
          if (is_reload(mode)) irq_flag_next = 1'b0;
          else                 ctrl_next[CTRL_EN_BIT] = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    Dout = '0;
    unique case (sel)
      REG_CTRL:   Dout = {{(DATA_W-CTRL_W){1'b0}}, ctrl_reg};
      REG_PRESET: Dout = preset_reg;
      REG_COUNT:  Dout = count_reg;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = ctrl_reg[CTRL_IM_BIT] & irq_flag_reg;

endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: directed plus random stimulus for timer_dev, checked every edge
// against a behavioural model of the timer's programmer-visible behaviour.
module tb_timer_dev;
  import timer_dev_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] Addr = '0;
  logic        WE = 1'b0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  timer_dev #(.DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .Addr (Addr),
    .WE   (WE),
    .Din  (Din),
    .Dout (Dout),
    .IRQ  (IRQ)
  );

  always #5 clk = ~clk;

  // Behavioural model: programmer-visible registers plus a progress phase
  // (0 waiting for enable, 1 loading, 2 counting, 3 just expired).
  logic [3:0]  m_ctrl = '0;
  logic [31:0] m_preset = '0;
  logic [31:0] m_count = '0;
  bit          m_flag = 1'b0;
  int          m_phase = 0;

  function automatic void model_edge(input bit rst_n, input bit we,
                                     input logic [31:0] a, input logic [31:0] d);
    if (!rst_n) begin
      m_ctrl = '0; m_preset = '0; m_count = '0; m_flag = 0; m_phase = 0;
    end else if (we) begin
      if (a[3:2] == 2'd0) begin m_ctrl = d[3:0]; m_flag = 0; end
      else if (a[3:2] == 2'd1) m_preset = d;
    end else begin
      case (m_phase)
        0: if (m_ctrl[0]) begin m_phase = 1; m_flag = 0; end
        1: begin m_count = m_preset; m_phase = 2; end
        2: if (m_ctrl[0]) begin
             if (m_count > 1) m_count = m_count - 1;
             else begin m_count = 0; m_flag = 1; m_phase = 3; end
           end
        default: begin
          if (m_ctrl[2:1] == 2'b01) m_flag = 0;
          else m_ctrl[0] = 1'b0;
          m_phase = 0;
        end
      endcase
    end
  endfunction

  function automatic logic [31:0] exp_dout(input int word);
    case (word)
      0: return {28'b0, m_ctrl};
      1: return m_preset;
      2: return m_count;
      default: return 32'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    Addr = TIMER1_BASE | 32'(off);
    #1;
    v = Dout;
  endtask

  task automatic check_all();
    logic [31:0] v;
    chk("irq", {31'b0, IRQ}, {31'b0, m_ctrl[3] & m_flag});
    for (int w = 0; w < 4; w++) begin
      rd(4'(w * 4), v);
      chk($sformatf("dout_off%0h", w * 4), v, exp_dout(w));
    end
  endtask

  task automatic step(input bit rst_n, input bit we, input logic [31:0] a, input logic [31:0] d);
    reset = rst_n; WE = we; Addr = a; Din = d;
    @(posedge clk);
    model_edge(rst_n, we, a, d);
    #1;
    WE = 1'b0;
    check_all();
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    step(1, 1, TIMER0_BASE | 32'(off), d);
  endtask
  task automatic idle();
    step(1, 0, TIMER0_BASE, 32'h0);
  endtask
  task automatic rst();
    step(0, 0, TIMER0_BASE, 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] ra;
    int r;

    // Reset
    rst(); rst();
    chk("rst_irq", {31'b0, IRQ}, 32'h0);
    rd(TIMER_COUNT, v);  chk("rst_count", v, 32'h0);

    // One-shot, PRESET=5, IM=1
    wr(TIMER_PRESET, 32'd5);
    wr(TIMER_CTRL, 32'h9);
    for (int k = 1; k <= 9; k++) begin
      idle();
      chk($sformatf("os_irq_k%0d", k), {31'b0, IRQ}, 32'(k >= 7));
      if (k == 2) begin rd(TIMER_COUNT, v); chk("os_count5", v, 32'd5); end
    end
    rd(TIMER_CTRL, v); chk("os_ctrl8", v, 32'h8);
    wr(TIMER_CTRL, 32'h8);
    chk("os_ack_irq", {31'b0, IRQ}, 32'h0);

    // Auto-reload, PRESET=3, period 6
    rst();
    wr(TIMER_PRESET, 32'd3);
    wr(TIMER_CTRL, 32'hB);
    for (int k = 1; k <= 18; k++) begin
      idle();
      chk($sformatf("ar_irq_k%0d", k), {31'b0, IRQ}, 32'(k == 5 || k == 11 || k == 17));
    end

    // Masked
    rst();
    wr(TIMER_PRESET, 32'd2);
    wr(TIMER_CTRL, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      idle();
      chk("mask_irq", {31'b0, IRQ}, 32'h0);
    end
    wr(TIMER_CTRL, 32'h8);
    idle();
    chk("mask_ack_irq", {31'b0, IRQ}, 32'h0);

    // Pause and ignored writes
    rst();
    wr(TIMER_PRESET, 32'd10);
    wr(TIMER_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) idle();
    rd(TIMER_COUNT, v); chk("pz_count6", v, 32'd6);
    wr(TIMER_CTRL, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      rd(TIMER_COUNT, v); chk("pz_hold", v, 32'd6);
    end
    wr(TIMER_COUNT, 32'd99);
    wr(4'hC, 32'd123);
    rd(TIMER_COUNT, v); chk("pz_count_ro", v, 32'd6);
    rd(4'hC, v);        chk("pz_offc", v, 32'd0);
    wr(TIMER_CTRL, 32'h1);
    idle();
    rd(TIMER_COUNT, v); chk("pz_resume", v, 32'd5);

    // Reset mid-count
    rst();
    wr(TIMER_PRESET, 32'd4);
    wr(TIMER_CTRL, 32'h9);
    for (int k = 1; k <= 4; k++) idle();
    rd(TIMER_COUNT, v); chk("mr_count2", v, 32'd2);
    rst();
    rd(TIMER_COUNT, v); chk("mr_count0", v, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      idle();
      chk("mr_irq", {31'b0, IRQ}, 32'h0);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      ra = $urandom();
      ra[1:0] = 2'b00;
      if (r < 2) rst();
      else if (r < 14) step(1, 1, ra, 32'($urandom_range(0, 15)));
      else step(1, 0, ra, $urandom());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped countdown timer that responds to CPU `lw`/`sw` traffic routed by the system bridge.
- The pipeline's address checker only admits these accesses:
  - Timer0 (base 0x7f00): lw at offsets 0x0, 0x4, 0x8; sw at offsets 0x0, 0x4.
  - Timer1 (base 0x7f10): same offsets.
- Two instances are built, one per base. The bridge does base decode and gates the write enable.
- Each instance raises an interrupt request to the CP0/interrupt logic when its count expires.

Parameters:
- DATA_W, 32, width of the PRESET and COUNT registers and of the data bus.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- Addr  in  32  byte address; only Addr[3:2] decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=unused).
- WE  in  1  write strobe, already qualified by the bridge's chip select.
- Din  in  DATA_W  write data.
- Dout  out  DATA_W  combinational read data for Addr[3:2].
- IRQ  out  1  interrupt request = CTRL.IM & irq_flag.

Behaviour:
- Register map:
  - CTRL: bit0 Enable, bits2:1 Mode, bit3 IM; bits31:4 read 0.
  - Mode 00 = one-shot, 01 = auto-reload; 1x behaves as 00.
  - PRESET: read/write.
  - COUNT: read-only; writes are ignored.
  - Offset 0xC reads 0; writes to it are ignored.
- Reset (reset==0 at an edge): CTRL=0, PRESET=0, COUNT=0, state=IDLE, irq_flag=0.
  - Hence IRQ=0, and Dout=0 for every address.
  - Reset mid-count aborts immediately; no interrupt is produced.
- Write cycle (WE=1):
  - The addressed register takes Din at the edge (CTRL takes Din[3:0]).
  - FSM state and COUNT hold for that edge; the write wins over any FSM update.
  - Any write to CTRL clears irq_flag; this is the software acknowledge.
- FSM, evaluated only on non-write, non-reset edges. States IDLE, LOAD, CNT, INT.
  - IDLE: if Enable, go to LOAD and clear irq_flag; else stay.
  - LOAD: COUNT<=PRESET, go to CNT; proceeds regardless of Enable.
  - CNT, Enable=0: COUNT and state hold (pause).
  - CNT, Enable=1, COUNT>1: COUNT<=COUNT-1.
  - CNT, Enable=1, COUNT<=1: COUNT<=0, irq_flag<=1, go to INT.
  - INT, Mode one-shot: CTRL.Enable<=0, go to IDLE; irq_flag stays 1 until acknowledged.
  - INT, Mode auto-reload: irq_flag<=0, go to IDLE. Enable is still 1, so the FSM reloads and restarts; IRQ is a single-cycle pulse.
- Latency:
  - From the CTRL-write edge with Enable=1 and PRESET=N≥1, irq_flag sets N+2 edges later.
  - PRESET=0 behaves as PRESET=1: irq_flag sets 3 edges after the write.
  - Auto-reload period is N+3 cycles.
- Arithmetic: unsigned DATA_W decrement; no wrap-around, since COUNT never decrements below 1.
- Dout is purely combinational from the registers and Addr; there is no read side effect.

Decomposition:
- Defined in constants.v:
  - TIMER0_BASE (0x7f00), TIMER1_BASE (0x7f10).
  - Offsets TIMER_CTRL (0), TIMER_PRESET (4), TIMER_COUNT (8).
  - Mode codes TIMER_MODE_ONESHOT (2'b00), TIMER_MODE_RELOAD (2'b01).
  - State codes for IDLE, LOAD, CNT, INT.
  - CTRL bit positions.
- Single module; no sub-module is natural, since the register file and FSM share every register.

Test Plan:
- Reset: hold reset=0 for 2 edges, then read all four offsets -> Dout=0 each; IRQ=0.
- One-shot: write PRESET=5, then CTRL=0x9 -> Expected sequence:
  - COUNT reads 5 two edges after the CTRL write.
  - IRQ rises exactly 7 edges after the CTRL write and stays high.
  - CTRL reads 0x8.
  - Writing CTRL=0x8 drops IRQ after the next edge.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ is a 1-cycle pulse at edges 5, 11, 17 after the write (period 6).
- Masked: PRESET=2, CTRL=0x1 -> IRQ stays 0; after a later write CTRL=0x8, IRQ is still 0 (flag cleared by the write).
- Pause/ignored writes: PRESET=10, CTRL=0x1; write CTRL=0x0 while COUNT=6 -> COUNT holds 6 for 5 cycles. Write COUNT=99 and offset 0xC -> COUNT still 6, 0xC reads 0. Rewrite CTRL=0x1 -> count resumes from 6.
- Reset mid-count: PRESET=4, CTRL=0x9; assert reset with COUNT=2 -> all registers 0, IRQ never asserts.
